mdu_core: RTL and testbench

//  Multiply/divide responder for the Ex stage; the other end of the start/busy handshake.
//  Ex pulses start with operands; mdu_core holds busy for a fixed latency, then commits HI/LO.

---
 rtl/md_pkg.sv | 21 ++
 rtl/md_calc.sv | 43 ++++
 rtl/mdu_core.sv | 83 ++++++++
 tb/tb_mdu_core.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared op codes, FSM encodings and the latched request type for the
// multiply/divide unit. The Ex-stage controller uses the same op codes.
package md_pkg;
  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } mdReq_t;

  function automatic logic isDivOp(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction
endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath. The result is only sampled by
// mdu_core on the final busy cycle.
module md_calc
  import md_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);
  logic [63:0] prodS, prodU;
  logic        negA, negB;
  logic [31:0] magA, magB, quo, rem, quoS, remS;

  // Signed product via sign-extended 64-bit operands; the low 64 bits are exact.
  assign prodS = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prodU = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes: quotient truncates toward zero, remainder
  // follows the dividend. 0x80000000 / -1 wraps back to 0x80000000.
  assign negA = (op == MD_DIV) && a[31];
  assign negB = (op == MD_DIV) && b[31];
  assign magA = negA ? -a : a;
  assign magB = (b == 32'd0) ? 32'd1 : (negB ? -b : b);
  assign quo  = magA / magB;
  assign rem  = magA % magB;
  assign quoS = (negA ^ negB) ? -quo : quo;
  assign remS = negA ? -rem : rem;

  assign div0 = isDivOp(op) && (b == 32'd0);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prodS;
      MD_MULTU: {res_hi, res_lo} = prodU;
      default:  begin res_hi = remS; res_lo = quoS; end
    endcase
  end
endmodule

// File: rtl/mdu_core.sv
// Multiply/divide responder: latches operands on start, holds busy for a
// fixed latency, then commits HI/LO. Also serves mthi/mtlo.
module mdu_core
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_en,
  input  logic        mt_hi,
  input  logic        mt_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          state;
  logic [CW-1:0] cnt;
  mdReq_t        req;
  logic [31:0]   resHi, resLo;
  logic          div0;

  // Arithmetic runs off the latched request so live operands may change.
  md_calc uCalc (
    .op    (req.op),
    .a     (req.a),
    .b     (req.b),
    .res_hi(resHi),
    .res_lo(resLo),
    .div0  (div0)
  );

  assign busy = (state == ST_BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      req   <= '0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && wr_en) begin
            req   <= '{op: op, a: a, b: b};
            cnt   <= isDivOp(op) ? DIV_LD : MULT_LD;
            state <= ST_BUSY;
          end else if (wr_en) begin
            if (mt_hi) hi <= a;
            if (mt_lo) lo <= a;
          end
        end
        default: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            // Divide by zero completes normally but leaves HI/LO untouched.
            if (!div0) begin
              hi <= resHi;
              lo <= resLo;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_core.sv
// Scoreboard bench for mdu_core: expected HI/LO and busy length are queued at
// issue and checked when done pulses.
module tb_mdu_core;
  import md_pkg::*;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, wr_en = 1'b0;
  logic        mt_hi = 1'b0, mt_lo = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done;

  mdu_core #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wr_en(wr_en), .mt_hi(mt_hi), .mt_lo(mt_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          nCmp = 0, nBad = 0, busyCnt = 0;
  logic [31:0] hiM = 32'd0, loM = 32'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if ((o == MD_DIV || o == MD_DIVU) && y == 32'd0) return {hiM, loM};
    case (o)
      MD_MULT:  begin p = sx * sy; return p; end
      MD_MULTU: return {32'd0, x} * {32'd0, y};
      MD_DIV:   begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
      default:  return {x % y, x / y};
    endcase
  endfunction

  // Monitor: count busy cycles and retire one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) busyCnt = 0;
    else begin
      if (busy) busyCnt++;
      if (done) begin
        if (sbq.size() == 0) chk("unexpDone", 64'd1, 64'd0);
        else begin
          e = sbq.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("busyCycles", busyCnt, e.lat);
        end
        busyCnt = 0;
      end
    end
  end

  task automatic waitIdle();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic pushExp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] r;
    r     = model(o, x, y);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.lat = (o == MD_DIV || o == MD_DIVU) ? 10 : 5;
    sbq.push_back(e);
    hiM = e.hi;
    loM = e.lo;
  endtask

  // Issue one op; operands are scrambled right after so a stale latch shows up.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic mtSame);
    @(posedge clk); #1;
    chk("idleAtStart", busy, 1'b0);
    start = 1'b1; wr_en = 1'b1; op = o; a = x; b = y;
    mt_hi = mtSame; mt_lo = mtSame;
    pushExp(o, x, y);
    @(posedge clk); #1;
    start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    waitIdle();
  endtask

  task automatic mtw(input logic hEn, input logic lEn, input logic [31:0] v, input logic we);
    @(posedge clk); #1;
    mt_hi = hEn; mt_lo = lEn; a = v; wr_en = we;
    if (we && hEn) hiM = v;
    if (we && lEn) loM = v;
    @(posedge clk); #1;
    mt_hi = 1'b0; mt_lo = 1'b0; wr_en = 1'b1;
    @(negedge clk);
    chk("mtHi", hi, hiM);
    chk("mtLo", lo, loM);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rstHi", hi, 32'd0);
    chk("rstLo", lo, 32'd0);
    chk("rstBusy", busy, 1'b0);
    chk("rstDone", done, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Directed arithmetic cases
    issue(MD_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(MD_DIVU,  32'd100, 32'd7, 1'b0);

    // mthi then divide by zero: HI/LO hold
    mtw(1'b1, 1'b0, 32'h0000_1234, 1'b1);
    issue(MD_DIVU, 32'd5, 32'd0, 1'b0);
    issue(MD_DIV,  32'd9, 32'd0, 1'b0);
    mtw(1'b1, 1'b1, 32'hCAFE_F00D, 1'b1);

    // start/mt gated off by wr_en
    @(posedge clk); #1;
    start = 1'b1; wr_en = 1'b0; op = MD_MULT; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("gatedBusy", busy, 1'b0);
    chk("gatedHi", hi, hiM);
    chk("gatedLo", lo, loM);
    mtw(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // mt in the same cycle as start loses to start
    issue(MD_MULT, 32'd3, 32'd4, 1'b1);

    // Async reset mid-mult: in-flight result discarded, no done
    @(posedge clk); #1;
    start = 1'b1; wr_en = 1'b1; op = MD_MULT; a = 32'd7; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midRstBusy", busy, 1'b0);
    chk("midRstHi", hi, 32'd0);
    chk("midRstLo", lo, 32'd0);
    chk("midRstDone", done, 1'b0);
    hiM = 32'd0; loM = 32'd0;
    @(posedge clk); #1 reset = 1'b1;
    repeat (8) @(negedge clk);
    issue(MD_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0);

    // Random mix, including occasional zero divisor
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      issue(2'($urandom), ra, rb, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("finalDrain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
